fetch_sequencer: RTL and testbench

Program-counter and fetch controller for the 16-bit single-cycle CPU.
- Drives the byte address into the instruction memory, which returns a combinational big-endian 16-bit word {Memory[a], Memory[a+1]}.
- Advances the PC by 2 per instruction and registers the fetched word into an instruction register for decode.
- Arbitrates, in priority order: reset, branch/jump redirect, pipeline stall and halt detection.

---
 rtl/fetch_sequencer_if.sv | 62 ++++++
 rtl/fetch_sequencer.sv | 165 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
// Bundles the fetch controller's control, instruction-memory and decode-side
// signals so the sequencer and its environment connect through one port.
//
// Optional feature macro: FETCH_PERF_COUNT_EN adds retired_count and
// bubble_count to the bundle.
//
// Signals:
//   start          one-cycle pulse that begins fetching from RESET_PC
//   stall          hold PC and IR this cycle
//   redirect_valid branch/jump taken this cycle
//   redirect_addr  byte target of the redirect
//   instr_data     combinational big-endian word from memory at mem_addr
//   mem_addr       byte address into instruction memory (always equals pc)
//   pc_out         current PC register
//   ir             registered instruction for decode
//   ir_valid       ir holds a valid instruction this cycle
//   halted         high while in HALT
//   misalign_err   sticky: an odd redirect target was seen
//
// Modports:
//   master  the fetch sequencer's view
//   slave   the environment's view (CPU core and instruction memory)
interface fetch_sequencer_if;
    logic        start;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic [15:0] instr_data;
    logic [15:0] mem_addr;
    logic [15:0] pc_out;
    logic [15:0] ir;
    logic        ir_valid;
    logic        halted;
    logic        misalign_err;
`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] retired_count;
    logic [15:0] bubble_count;

    modport master (
        input  start, stall, redirect_valid, redirect_addr, instr_data,
        output mem_addr, pc_out, ir, ir_valid, halted, misalign_err,
        output retired_count, bubble_count
    );

    modport slave (
        output start, stall, redirect_valid, redirect_addr, instr_data,
        input  mem_addr, pc_out, ir, ir_valid, halted, misalign_err,
        input  retired_count, bubble_count
    );
`else
    modport master (
        input  start, stall, redirect_valid, redirect_addr, instr_data,
        output mem_addr, pc_out, ir, ir_valid, halted, misalign_err
    );

    modport slave (
        output start, stall, redirect_valid, redirect_addr, instr_data,
        input  mem_addr, pc_out, ir, ir_valid, halted, misalign_err
    );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Program counter and fetch controller for the 16-bit single-cycle CPU.
// Drives the PC onto the instruction memory address, registers the returned
// word into the instruction register, and arbitrates redirect, stall and
// halt-word detection. The PC advances by PC_STEP and wraps modulo MEM_BYTES.
//
// Optional feature macro: FETCH_PERF_COUNT_EN adds saturating retired and
// bubble counters (retired_count, bubble_count on the interface).
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    fetch_sequencer_if.master (control inputs, memory bus, IR outputs)
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int unsigned PC_STEP    = 2,
    parameter int unsigned MEM_BYTES  = 256,
    parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    // Masking with MEM_BYTES-1 keeps every PC bit above the memory range at 0.
    localparam logic [15:0] PC_MASK  = 16'(MEM_BYTES - 1);
    localparam logic [15:0] STEP     = 16'(PC_STEP);
    localparam logic [15:0] START_PC = RESET_PC & PC_MASK;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic        misalign_q, misalign_d;
`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] retired_q, retired_d;
    logic [15:0] bubble_q, bubble_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= START_PC;
            ir_q       <= 16'h0000;
            ir_valid_q <= 1'b0;
            misalign_q <= 1'b0;
`ifdef FETCH_PERF_COUNT_EN
            retired_q  <= 16'h0000;
            bubble_q   <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            misalign_q <= misalign_d;
`ifdef FETCH_PERF_COUNT_EN
            retired_q  <= retired_d;
            bubble_q   <= bubble_d;
`endif
        end
    end

    // In RUN the arbitration order is redirect, then stall, then halt-word
    // detection, then a normal fetch. A redirect still wins while stalled.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        misalign_d = misalign_q;
`ifdef FETCH_PERF_COUNT_EN
        retired_d  = retired_q;
        bubble_d   = bubble_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = RUN;
                    pc_d       = START_PC;
                    ir_valid_d = 1'b0;
`ifdef FETCH_PERF_COUNT_EN
                    retired_d  = 16'h0000;
                    bubble_d   = 16'h0000;
`endif
                end
            end

            RUN: begin
                if (bus.redirect_valid) begin
                    ir_valid_d = 1'b0;
`ifdef FETCH_PERF_COUNT_EN
                    if (bubble_q != 16'hFFFF) begin
                        bubble_d = bubble_q + 16'd1;
                    end
`endif
                    // An odd target cannot hold a 16-bit instruction: flag
                    // it and stop, leaving the PC where it was.
                    if (bus.redirect_addr[0]) begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        pc_d = bus.redirect_addr & PC_MASK;
                    end
                end else if (bus.stall) begin
`ifdef FETCH_PERF_COUNT_EN
                    if (bubble_q != 16'hFFFF) begin
                        bubble_d = bubble_q + 16'd1;
                    end
`endif
                end else if (bus.instr_data == HALT_INSTR) begin
                    // PC stays on the halt word so software can see where it stopped.
                    state_d    = HALT;
                    ir_valid_d = 1'b0;
                end else begin
                    ir_d       = bus.instr_data;
                    ir_valid_d = 1'b1;
                    pc_d       = (pc_q + STEP) & PC_MASK;
`ifdef FETCH_PERF_COUNT_EN
                    if (retired_q != 16'hFFFF) begin
                        retired_d = retired_q + 16'd1;
                    end
`endif
                end
            end

            HALT: begin
                if (bus.start) begin
                    state_d    = RUN;
                    pc_d       = START_PC;
                    misalign_d = 1'b0;
                    ir_valid_d = 1'b0;
`ifdef FETCH_PERF_COUNT_EN
                    retired_d  = 16'h0000;
                    bubble_d   = 16'h0000;
`endif
                end
            end

            default: begin
                state_d    = IDLE;
                ir_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.mem_addr     = pc_q;
    assign bus.pc_out       = pc_q;
    assign bus.ir           = ir_q;
    assign bus.ir_valid     = ir_valid_q;
    assign bus.halted       = (state_q == HALT);
    assign bus.misalign_err = misalign_q;
`ifdef FETCH_PERF_COUNT_EN
    assign bus.retired_count = retired_q;
    assign bus.bubble_count  = bubble_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer. A byte-array instruction memory
// feeds the DUT. A behavioural model of the fetch rules predicts every output
// after each clock edge. Directed steps come first, then randomized stall,
// redirect and start traffic against random memory contents.
// Honours FETCH_PERF_COUNT_EN to also check the perf counters.
module tb_fetch_sequencer;

    logic clk;
    logic reset;

    fetch_sequencer_if bus();

    fetch_sequencer #(
        .RESET_PC   (16'h0000),
        .PC_STEP    (2),
        .MEM_BYTES  (256),
        .HALT_INSTR (16'hFFFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:255];
    logic [7:0] rd_lo;
    logic [7:0] rd_hi;

    // Big-endian combinational read: {Memory[a], Memory[a+1]}.
    assign rd_lo = bus.mem_addr[7:0];
    assign rd_hi = rd_lo + 8'd1;
    assign bus.instr_data = {mem[rd_lo], mem[rd_hi]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic        m_running;
    logic        m_halted;
    logic [15:0] m_pc;
    logic [15:0] m_ir;
    logic        m_valid;
    logic        m_err;
    logic [15:0] m_retired;
    logic [15:0] m_bubbles;

    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        logic [7:0] a;
        logic [7:0] b;
        a = addr[7:0];
        b = a + 8'd1;
        return {mem[a], mem[b]};
    endfunction

    task automatic model_reset();
        m_running = 1'b0;
        m_halted  = 1'b0;
        m_pc      = 16'h0000;
        m_ir      = 16'h0000;
        m_valid   = 1'b0;
        m_err     = 1'b0;
        m_retired = 16'h0000;
        m_bubbles = 16'h0000;
    endtask

    // Predicts the effect of the next rising edge from the current inputs.
    task automatic model_step();
        logic [15:0] word;
        if (!m_running) begin
            if (bus.start) begin
                m_running = 1'b1;
                m_halted  = 1'b0;
                m_pc      = 16'h0000;
                m_err     = 1'b0;
                m_valid   = 1'b0;
                m_retired = 16'h0000;
                m_bubbles = 16'h0000;
            end
        end else if (bus.redirect_valid) begin
            m_valid = 1'b0;
            if (m_bubbles != 16'hFFFF) m_bubbles = m_bubbles + 16'd1;
            if ((bus.redirect_addr % 2) == 1) begin
                m_err     = 1'b1;
                m_running = 1'b0;
                m_halted  = 1'b1;
            end else begin
                m_pc = bus.redirect_addr % 16'd256;
            end
        end else if (bus.stall) begin
            if (m_bubbles != 16'hFFFF) m_bubbles = m_bubbles + 16'd1;
        end else begin
            word = mem_word(m_pc);
            if (word == 16'hFFFF) begin
                m_running = 1'b0;
                m_halted  = 1'b1;
                m_valid   = 1'b0;
            end else begin
                m_ir    = word;
                m_valid = 1'b1;
                m_pc    = (m_pc + 16'd2) % 16'd256;
                if (m_retired != 16'hFFFF) m_retired = m_retired + 16'd1;
            end
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check16({tag, "_pc"},       bus.pc_out,   m_pc);
        check16({tag, "_mem_addr"}, bus.mem_addr, m_pc);
        check16({tag, "_ir"},       bus.ir,       m_ir);
        check16({tag, "_ir_valid"}, {15'd0, bus.ir_valid},     {15'd0, m_valid});
        check16({tag, "_halted"},   {15'd0, bus.halted},       {15'd0, m_halted});
        check16({tag, "_misalign"}, {15'd0, bus.misalign_err}, {15'd0, m_err});
`ifdef FETCH_PERF_COUNT_EN
        check16({tag, "_retired"},  bus.retired_count, m_retired);
        check16({tag, "_bubbles"},  bus.bubble_count,  m_bubbles);
`endif
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset              = 1'b0;
        bus.start          = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5C);
        mem[0] = 8'h31; mem[1] = 8'h12;
        mem[2] = 8'h34; mem[3] = 8'h13;
        mem[4] = 8'h01; mem[5] = 8'h02;
        mem[6] = 8'h40; mem[7] = 8'h41;
        mem[8] = 8'hFF; mem[9] = 8'hFF;
        mem[254] = 8'hA5; mem[255] = 8'h5A;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b1;
        tick("idle_hold");

        // Sequential fetch into the halt word at byte 8
        bus.start = 1'b1;
        tick("tp1_start");
        bus.start = 1'b0;
        tick("tp1_f0");
        check16("tp1_ir0", bus.ir, 16'h3112);
        tick("tp1_f1");
        check16("tp1_ir1", bus.ir, 16'h3413);
        tick("tp1_f2");
        check16("tp1_ir2", bus.ir, 16'h0102);
        tick("tp1_f3");
        check16("tp1_ir3", bus.ir, 16'h4041);
        tick("tp1_halt");
        check16("tp1_halt_pc", bus.pc_out, 16'h0008);
        check16("tp1_halted", {15'd0, bus.halted}, 16'd1);
        tick("tp1_halt_hold");

        // Redirect back to 0 from pc=4
        mem[8] = 8'h55; mem[9] = 8'hAA;
        bus.start = 1'b1;
        tick("tp2_start");
        bus.start = 1'b0;
        tick("tp2_f0");
        tick("tp2_f1");
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 16'h0000;
        tick("tp2_redir");
        check16("tp2_pc", bus.pc_out, 16'h0000);
        check16("tp2_bubble", {15'd0, bus.ir_valid}, 16'd0);
        bus.redirect_valid = 1'b0;
        tick("tp2_refetch");
        check16("tp2_ir", bus.ir, 16'h3112);

        // Three-cycle stall at pc=2
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("tp3_stall");
            check16("tp3_pc_hold", bus.pc_out, 16'h0002);
        end
        bus.stall = 1'b0;
        tick("tp3_resume");
        check16("tp3_ir", bus.ir, 16'h3413);

        // Misaligned redirect at pc=4, halted state ignores stall/redirect
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 16'h0005;
        tick("tp4_misalign");
        check16("tp4_err", {15'd0, bus.misalign_err}, 16'd1);
        check16("tp4_pc", bus.pc_out, 16'h0004);
        for (int i = 0; i < 3; i++) begin
            bus.stall          = 1'($urandom_range(0, 1));
            bus.redirect_valid = 1'($urandom_range(0, 1));
            bus.redirect_addr  = 16'($urandom);
            tick("tp4_frozen");
        end
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.start          = 1'b1;
        tick("tp4_restart");
        check16("tp4_err_clear", {15'd0, bus.misalign_err}, 16'd0);
        bus.start = 1'b0;
        tick("tp4_f0");

        // Redirect to the last word, then wrap to 0
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 16'h00FE;
        tick("tp5_redir");
        bus.redirect_valid = 1'b0;
        tick("tp5_last");
        check16("tp5_ir_last", bus.ir, 16'hA55A);
        check16("tp5_wrap_pc", bus.pc_out, 16'h0000);
        tick("tp5_wrapped");
        check16("tp5_ir_first", bus.ir, 16'h3112);

        // Asynchronous reset at pc=6 while stalled
        tick("tp6_f1");
        tick("tp6_f2");
        bus.stall = 1'b1;
        tick("tp6_stall");
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("tp6_async");
        check16("tp6_ir_zero", bus.ir, 16'h0000);
        #1;
        reset     = 1'b1;
        bus.stall = 1'b0;
        tick("tp6_idle");

        // Randomized traffic over random memory with sparse halt words
        for (int i = 0; i < 256; i += 2) begin
            if ($urandom_range(0, 31) == 0) begin
                mem[i] = 8'hFF; mem[i+1] = 8'hFF;
            end else begin
                mem[i] = 8'($urandom); mem[i+1] = 8'($urandom);
            end
        end
        bus.start = 1'b1;
        tick("rnd_start");
        for (int i = 0; i < 400; i++) begin
            bus.start          = ($urandom_range(0, 19) == 0);
            bus.stall          = ($urandom_range(0, 4) == 0);
            bus.redirect_valid = ($urandom_range(0, 9) == 0);
            bus.redirect_addr  = 16'($urandom);
            if ($urandom_range(0, 7) != 0) bus.redirect_addr[0] = 1'b0;
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
